// File: rtl/ps2_key_pkg.sv
// Shared constants and types for the PS/2 set-2 key tracker.
// Holds the prefix byte values, slot indices, the slot code table,
// the FSM state encoding and the decoded key event payload.
package ps2_key_pkg;

    localparam int unsigned NUM_KEYS = 8;
    localparam int unsigned SLOT_W   = 3;
    localparam int unsigned CODE_W   = 8;

    localparam logic [CODE_W-1:0] PFX_EXT   = 8'hE0;
    localparam logic [CODE_W-1:0] PFX_BRK   = 8'hF0;
    localparam logic [CODE_W-1:0] PFX_PAUSE = 8'hE1;

    localparam logic [SLOT_W-1:0] SLOT_A     = 3'd0;
    localparam logic [SLOT_W-1:0] SLOT_D     = 3'd1;
    localparam logic [SLOT_W-1:0] SLOT_W_KEY = 3'd2;
    localparam logic [SLOT_W-1:0] SLOT_S     = 3'd3;
    localparam logic [SLOT_W-1:0] SLOT_R     = 3'd4;
    localparam logic [SLOT_W-1:0] SLOT_SPACE = 3'd5;
    localparam logic [SLOT_W-1:0] SLOT_LEFT  = 3'd6;
    localparam logic [SLOT_W-1:0] SLOT_RIGHT = 3'd7;

    // A scan code qualified by whether it followed an E0 prefix.
    typedef struct packed {
        logic              ext;
        logic [CODE_W-1:0] code;
    } key_code_t;

    // Fully resolved key event produced by the prefix decoder.
    typedef struct packed {
        logic      make;
        logic      brk;
        key_code_t key;
    } key_evt_t;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_EXT     = 3'd1,
        ST_BRK     = 3'd2,
        ST_EXT_BRK = 3'd3,
        ST_SKIP    = 3'd4
    } state_t;

    // Code table: which {ext, code} pair each slot answers to.
    function automatic key_code_t slot_code(input logic [SLOT_W-1:0] slot);
        key_code_t k;
        case (slot)
            SLOT_A:     k = '{ext: 1'b0, code: 8'h1C};
            SLOT_D:     k = '{ext: 1'b0, code: 8'h23};
            SLOT_W_KEY: k = '{ext: 1'b0, code: 8'h1D};
            SLOT_S:     k = '{ext: 1'b0, code: 8'h1B};
            SLOT_R:     k = '{ext: 1'b0, code: 8'h2D};
            SLOT_SPACE: k = '{ext: 1'b0, code: 8'h29};
            SLOT_LEFT:  k = '{ext: 1'b1, code: 8'h6B};
            default:    k = '{ext: 1'b1, code: 8'h74};
        endcase
        return k;
    endfunction

endpackage

// File: rtl/ps2_key_slot_lookup.sv
// Combinational map from a qualified scan code to a key slot.
// Ports:
//   key     in  {ext, code} to look up
//   hit_c   out 1 when the code belongs to one of the tracked slots
//   slot_c  out slot index (valid only with hit_c)
module ps2_key_slot_lookup
    import ps2_key_pkg::*;
(
    input  key_code_t         key,
    output logic              hit_c,
    output logic [SLOT_W-1:0] slot_c
);

    // Linear search of the slot table; ext must match as well as the code.
    always_comb begin
        hit_c  = 1'b0;
        slot_c = '0;
        for (int unsigned i = 0; i < NUM_KEYS; i++) begin
            if (!hit_c && (slot_code(SLOT_W'(i)) == key)) begin
                hit_c  = 1'b1;
                slot_c = SLOT_W'(i);
            end
        end
    end

endmodule

// File: rtl/ps2_key_tracker.sv
// PS/2 set-2 key tracker: resolves E0/F0/E1 prefix sequences from ps2_rx
// bytes, keeps a held bitmap for 8 mapped keys and produces one-cycle
// press/release pulses with typematic repeats suppressed.
// Ports:
//   clk           system clock
//   reset         asynchronous active-high reset
//   rx_done_tick  one-cycle strobe, scan_code valid
//   scan_code     received byte
//   key_held      level per slot, key currently down
//   key_press     one-cycle pulse on first make of a key
//   key_release   one-cycle pulse on break of a held key
//   seq_error     one-cycle pulse on prefix timeout or unexpected prefix
module ps2_key_tracker
    import ps2_key_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned PAUSE_SKIP  = 7
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                rx_done_tick,
    input  logic [CODE_W-1:0]   scan_code,
    output logic [NUM_KEYS-1:0] key_held,
    output logic [NUM_KEYS-1:0] key_press,
    output logic [NUM_KEYS-1:0] key_release,
    output logic                seq_error
);

    localparam int unsigned TMO_W  = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int unsigned SKIP_W = (PAUSE_SKIP > 2) ? $clog2(PAUSE_SKIP) : 1;
    localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(TIMEOUT_CYC - 1);
    localparam logic [SKIP_W-1:0] SKIP_LOAD = SKIP_W'(PAUSE_SKIP - 1);

    state_t              state, state_nxt;
    logic [SKIP_W-1:0]   skip_cnt, skip_nxt;
    logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
    key_evt_t            evt_c;
    logic                err_c;
    logic                tmo_expire_c;
    logic                is_prefix_c;
    logic                hit_c;
    logic [SLOT_W-1:0]   slot_c;
    logic [NUM_KEYS-1:0] held_nxt, press_nxt, release_nxt;

    ps2_key_slot_lookup u_lookup (
        .key    (evt_c.key),
        .hit_c  (hit_c),
        .slot_c (slot_c)
    );

    // State register plus skip and timeout counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            skip_cnt <= '0;
            tmo_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            skip_cnt <= skip_nxt;
            tmo_cnt  <= tmo_nxt;
        end
    end

    // Next-state: prefix decoding, event generation and timeout handling.
    always_comb begin
        state_nxt   = state;
        skip_nxt    = skip_cnt;
        tmo_nxt     = tmo_cnt;
        evt_c       = '0;
        err_c       = 1'b0;
        is_prefix_c = (scan_code == PFX_EXT) || (scan_code == PFX_BRK) ||
                      (scan_code == PFX_PAUSE);
        // A byte arriving in the expiry cycle takes precedence over the timeout.
        tmo_expire_c = (state != ST_IDLE) && !rx_done_tick && (tmo_cnt == TMO_LAST);

        if (rx_done_tick) begin
            tmo_nxt = '0;
        end else if ((state != ST_IDLE) && (tmo_cnt != TMO_LAST)) begin
            tmo_nxt = tmo_cnt + TMO_W'(1);
        end

        if (rx_done_tick) begin
            case (state)
                ST_IDLE: begin
                    if (scan_code == PFX_EXT) begin
                        state_nxt = ST_EXT;
                    end else if (scan_code == PFX_BRK) begin
                        state_nxt = ST_BRK;
                    end else if (scan_code == PFX_PAUSE) begin
                        state_nxt = ST_SKIP;
                        skip_nxt  = SKIP_LOAD;
                    end else begin
                        evt_c.make     = 1'b1;
                        evt_c.key.code = scan_code;
                    end
                end
                ST_EXT: begin
                    if (scan_code == PFX_BRK) begin
                        state_nxt = ST_EXT_BRK;
                    end else if (is_prefix_c) begin
                        state_nxt = ST_IDLE;
                        err_c     = 1'b1;
                    end else begin
                        state_nxt      = ST_IDLE;
                        evt_c.make     = 1'b1;
                        evt_c.key.ext  = 1'b1;
                        evt_c.key.code = scan_code;
                    end
                end
                ST_BRK, ST_EXT_BRK: begin
                    state_nxt = ST_IDLE;
                    if (is_prefix_c) begin
                        err_c = 1'b1;
                    end else begin
                        evt_c.brk      = 1'b1;
                        evt_c.key.ext  = (state == ST_EXT_BRK);
                        evt_c.key.code = scan_code;
                    end
                end
                ST_SKIP: begin
                    if (skip_cnt == '0) begin
                        state_nxt = ST_IDLE;
                    end else begin
                        skip_nxt = skip_cnt - SKIP_W'(1);
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end else if (tmo_expire_c) begin
            state_nxt = ST_IDLE;
            err_c     = 1'b1;
        end
    end

    // Outputs: apply the resolved event to the held bitmap and pulse registers.
    always_comb begin
        held_nxt    = key_held;
        press_nxt   = '0;
        release_nxt = '0;
        if (hit_c) begin
            if (evt_c.make && !key_held[slot_c]) begin
                held_nxt[slot_c]  = 1'b1;
                press_nxt[slot_c] = 1'b1;
            end else if (evt_c.brk && key_held[slot_c]) begin
                held_nxt[slot_c]    = 1'b0;
                release_nxt[slot_c] = 1'b1;
            end
        end
    end

    // Registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            key_held    <= '0;
            key_press   <= '0;
            key_release <= '0;
            seq_error   <= 1'b0;
        end else begin
            key_held    <= held_nxt;
            key_press   <= press_nxt;
            key_release <= release_nxt;
            seq_error   <= err_c;
        end
    end

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Self-checking bench for ps2_key_tracker: directed scenarios followed by
// random byte streams, compared against a prefix-flag reference model.
module tb_ps2_key_tracker;

    localparam int unsigned TMO  = 100;
    localparam int unsigned SKIP = 7;

    logic       clk = 1'b0;
    logic       reset;
    logic       rx_done_tick;
    logic [7:0] scan_code;
    logic [7:0] key_held, key_press, key_release;
    logic       seq_error;

    ps2_key_tracker #(.TIMEOUT_CYC(TMO), .PAUSE_SKIP(SKIP)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_done_tick (rx_done_tick),
        .scan_code    (scan_code),
        .key_held     (key_held),
        .key_press    (key_press),
        .key_release  (key_release),
        .seq_error    (seq_error)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;

    // Reference model: key table plus pending-prefix flags and a discard count.
    localparam logic [7:0] MAP_CODE [8] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D, 8'h29, 8'h6B, 8'h74};
    localparam bit         MAP_EXT  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};

    logic [7:0] m_held;
    bit         m_ext, m_brk;
    int         m_skip;
    logic [7:0] e_press, e_rel;
    logic       e_err;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    function automatic int find_slot(input bit ext, input logic [7:0] code);
        for (int i = 0; i < 8; i++)
            if (MAP_EXT[i] == ext && MAP_CODE[i] == code) return i;
        return -1;
    endfunction

    task automatic model_reset();
        m_held = '0; m_ext = 0; m_brk = 0; m_skip = 0;
        e_press = '0; e_rel = '0; e_err = 0;
    endtask

    task automatic model_timeout();
        m_ext = 0; m_brk = 0; m_skip = 0;
        e_press = '0; e_rel = '0; e_err = 1;
    endtask

    task automatic model_step(input logic [7:0] b);
        int s;
        e_press = '0; e_rel = '0; e_err = 0;
        if (m_skip > 0) begin
            m_skip--;
        end else if (b == 8'hE1 || b == 8'hE0 || b == 8'hF0) begin
            // A prefix is legal only where nothing incompatible is pending.
            if (b == 8'hE1 && !m_ext && !m_brk)      m_skip = SKIP;
            else if (b == 8'hE0 && !m_ext && !m_brk) m_ext = 1;
            else if (b == 8'hF0 && !m_brk)           m_brk = 1;
            else begin
                e_err = 1; m_ext = 0; m_brk = 0;
            end
        end else begin
            s = find_slot(m_ext, b);
            if (s >= 0) begin
                if (!m_brk && !m_held[s]) begin
                    m_held[s] = 1'b1; e_press[s] = 1'b1;
                end else if (m_brk && m_held[s]) begin
                    m_held[s] = 1'b0; e_rel[s] = 1'b1;
                end
            end
            m_ext = 0; m_brk = 0;
        end
    endtask

    task automatic check_pulses(input string tag);
        check({tag, " held"},  key_held,           m_held);
        check({tag, " press"}, key_press,          e_press);
        check({tag, " rel"},   key_release,        e_rel);
        check({tag, " err"},   {7'b0, seq_error},  {7'b0, e_err});
    endtask

    // Drive one byte for one cycle, check the reaction, then check pulses drop.
    task automatic send_byte(input logic [7:0] b, input string tag);
        @(negedge clk);
        scan_code    = b;
        rx_done_tick = 1'b1;
        model_step(b);
        @(posedge clk); #1;
        check_pulses(tag);
        @(negedge clk);
        rx_done_tick = 1'b0;
        @(posedge clk); #1;
        e_press = '0; e_rel = '0; e_err = 0;
        check_pulses({tag, " next"});
    endtask

    logic [7:0] pool [14] = '{8'h1C, 8'h23, 8'h1D, 8'h1B, 8'h2D, 8'h29, 8'h6B, 8'h74,
                              8'hE0, 8'hF0, 8'hF0, 8'hE1, 8'h12, 8'h5A};

    initial begin
        int n;
        reset        = 1'b1;
        rx_done_tick = 1'b0;
        scan_code    = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_pulses("reset");
        @(negedge clk);
        reset = 1'b0;

        // 1) W make then break
        send_byte(8'h1D, "t1 make");
        send_byte(8'hF0, "t1 f0");
        send_byte(8'h1D, "t1 brk");

        // 2) typematic repeats of A
        send_byte(8'h1C, "t2 a0");
        send_byte(8'h1C, "t2 a1");
        send_byte(8'h1C, "t2 a2");
        send_byte(8'hF0, "t2 f0");
        send_byte(8'h1C, "t2 brk");

        // 3) extended left arrow; plain 6B does nothing
        send_byte(8'hE0, "t3 e0");
        send_byte(8'h6B, "t3 make");
        send_byte(8'hE0, "t3 e0b");
        send_byte(8'hF0, "t3 f0");
        send_byte(8'h6B, "t3 brk");
        send_byte(8'h6B, "t3 plain");
        send_byte(8'hE0, "t3 e0c");
        send_byte(8'h1C, "t3 e0_1c");

        // 4) prefix timeout, then space
        send_byte(8'hE0, "t4 e0");
        n = 1;
        while (seq_error !== 1'b1 && n < 3 * TMO) begin
            @(posedge clk); #1;
            n++;
        end
        model_timeout();
        check("t4 tmo seen",  {7'b0, seq_error}, 8'h01);
        check("t4 tmo cycle", 8'(n), 8'(TMO));
        check("t4 tmo held",  key_held, m_held);
        @(posedge clk); #1;
        check("t4 tmo drop",  {7'b0, seq_error}, 8'h00);
        send_byte(8'h29, "t4 space");

        // Byte landing in the expiry cycle beats the timeout
        send_byte(8'hE0, "t4b e0");
        repeat (TMO - 2) @(posedge clk);
        send_byte(8'h6B, "t4b race");
        send_byte(8'hE0, "t4b e0r");
        send_byte(8'hF0, "t4b f0");
        send_byte(8'h6B, "t4b brk");

        // 5) Pause sequence swallows 7 bytes
        send_byte(8'hE1, "t5 e1");
        send_byte(8'h14, "t5 s1");
        send_byte(8'h1C, "t5 s2");
        send_byte(8'hF0, "t5 s3");
        send_byte(8'h1C, "t5 s4");
        send_byte(8'hF0, "t5 s5");
        send_byte(8'h14, "t5 s6");
        send_byte(8'h1C, "t5 s7");
        send_byte(8'h23, "t5 d");

        // Unexpected prefixes
        send_byte(8'hF0, "t5b f0");
        send_byte(8'hE0, "t5b bad");
        send_byte(8'hE0, "t5b e0");
        send_byte(8'hE1, "t5b bad2");

        // 6) reset mid-sequence while R is held
        send_byte(8'h2D, "t6 r");
        send_byte(8'hE0, "t6 e0");
        send_byte(8'hF0, "t6 f0");
        @(negedge clk);
        reset = 1'b1;
        #1;
        model_reset();
        check_pulses("t6 rst");
        @(negedge clk);
        reset = 1'b0;
        send_byte(8'hF0, "t6 f0b");
        send_byte(8'h2D, "t6 stray");

        // Random byte streams
        for (int i = 0; i < 400; i++)
            send_byte(pool[$urandom_range(0, 13)], "rnd");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
